// File: rtl/div_unit.sv
// div_unit -- iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and
// their 32-bit (W) forms, with RV64M divide-by-zero and overflow results.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   div_valid_i   request valid          div_ready_o   idle, request accepted
//   div_op_i      one-hot op: [0] div, [1] divu, [2] rem, [3] remu
//   inst_32bit_i  W form (low 32 bits, result sign-extended from bit 31)
//   div_src1_i    dividend               div_src2_i    divisor
//   flush_i       abandon any in-flight operation
//   res_valid_o   result valid           res_ready_i   consumer takes result
//   div_result_o  quotient or remainder
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request, div_ready_o=1
// CALC  | cnt_q>0: one quotient bit per cycle; cnt_q==0: sign fix-up and
//       | format into the result register
// DONE  | res_valid_o=1, result held until res_ready_i
module div_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  input  logic [3:0]       div_op_i,
  input  logic             inst_32bit_i,
  input  logic [WIDTH-1:0] div_src1_i,
  input  logic [WIDTH-1:0] div_src2_i,
  input  logic             flush_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] div_result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic             w_q, w_d;

  // Request decode, only meaningful in the accept cycle.
  logic             op_signed, op_rem, op_onehot;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic             a_neg, b_neg, b_zero, ovf;

  always_comb begin
    op_signed = div_op_i[0] | div_op_i[2];
    op_rem    = div_op_i[2] | div_op_i[3];
    op_onehot = $onehot(div_op_i);
    if (inst_32bit_i) begin
      a_ext   = {{(WIDTH-32){op_signed & div_src1_i[31]}}, div_src1_i[31:0]};
      b_ext   = {{(WIDTH-32){op_signed & div_src2_i[31]}}, div_src2_i[31:0]};
      min_val = {{(WIDTH-31){1'b1}}, {31{1'b0}}};
    end else begin
      a_ext   = div_src1_i;
      b_ext   = div_src2_i;
      min_val = {1'b1, {(WIDTH-1){1'b0}}};
    end
    a_neg  = op_signed & a_ext[WIDTH-1];
    b_neg  = op_signed & b_ext[WIDTH-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = op_signed && (a_ext == min_val) && (b_ext == '1);
  end

  // One restoring step. The partial remainder is widened by two bits so the
  // shifted value (< 2*divisor) never overflows; any nonzero top bit means
  // the trial subtraction went negative.
  logic [WIDTH:0]   rem_sh;
  logic [1:0]       diff_hi;
  logic [WIDTH-1:0] diff_lo;
  logic             borrow;

  always_comb begin
    rem_sh            = {rem_q, quo_q[WIDTH-1]};
    {diff_hi, diff_lo} = {1'b0, rem_sh} - {2'b00, dvs_q};
    borrow            = (diff_hi != 2'b00);
  end

  // Sign fix-up and W-form sign extension of the finished operation.
  logic [WIDTH-1:0] q_fin, r_fin, raw, res_fmt;

  always_comb begin
    q_fin   = neg_quo_q ? -quo_q : quo_q;
    r_fin   = neg_rem_q ? -rem_q : rem_q;
    raw     = is_rem_q ? r_fin : q_fin;
    res_fmt = w_q ? {{(WIDTH-32){raw[31]}}, raw[31:0]} : raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    w_d       = w_q;

    case (state_q)
      S_IDLE: begin
        if (div_valid_i && !flush_i) begin
          state_d   = S_CALC;
          is_rem_d  = op_rem;
          w_d       = inst_32bit_i;
          dvs_d     = b_mag;
          rem_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          cnt_d     = '0;
          // Special cases preload the final quotient/remainder and skip the
          // iteration; they still spend one CALC cycle for the fix-up path.
          if (!op_onehot) begin
            quo_d = '0;
          end else if (b_zero) begin
            quo_d = '1;
            rem_d = a_ext;
          end else if (ovf) begin
            quo_d = a_ext;
          end else begin
            // W dividends sit in the top half so the MSB-first shift works
            // for 32 steps; the quotient then lands in the low half.
            quo_d     = inst_32bit_i ? {a_mag[31:0], {(WIDTH-32){1'b0}}} : a_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = inst_32bit_i ? CW'(32) : CW'(WIDTH);
          end
        end
      end
      S_CALC: begin
        if (cnt_q != '0) begin
          rem_d = borrow ? rem_sh[WIDTH-1:0] : diff_lo;
          quo_d = {quo_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_DONE;
          if (!flush_i) res_d = res_fmt;
        end
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      w_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      w_q       <= w_d;
    end
  end

  assign div_ready_o  = (state_q == S_IDLE);
  assign res_valid_o  = (state_q == S_DONE);
  assign div_result_o = res_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic [3:0]  div_op = 4'd0;
  logic        inst_32bit = 1'b0;
  logic [63:0] div_src1 = 64'd0;
  logic [63:0] div_src2 = 64'd0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] div_result;

  int total = 0;
  int bad = 0;

  localparam logic [3:0] OP_DIV = 4'b0001, OP_DIVU = 4'b0010,
                         OP_REM = 4'b0100, OP_REMU = 4'b1000;

  div_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .div_valid_i(div_valid), .div_ready_o(div_ready),
    .div_op_i(div_op), .inst_32bit_i(inst_32bit),
    .div_src1_i(div_src1), .div_src2_i(div_src2),
    .flush_i(flush),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .div_result_o(div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain language arithmetic plus the RV64M corner-case rules.
  function automatic logic [63:0] ref_div(input logic [3:0] op, input bit w,
                                          input logic [63:0] s1, input logic [63:0] s2);
    longint sa, sb;
    longint unsigned ua, ub;
    int wa, wb;
    int unsigned wua, wub;
    logic [31:0] r32;
    logic [63:0] r64;
    bit ovf32, ovf64;
    if (!$onehot(op)) return 64'd0;
    sa = s1; sb = s2; ua = s1; ub = s2;
    wa = s1[31:0]; wb = s2[31:0]; wua = s1[31:0]; wub = s2[31:0];
    ovf32 = (s1[31:0] == 32'h8000_0000) && (s2[31:0] == 32'hFFFF_FFFF);
    ovf64 = (s1 == 64'h8000_0000_0000_0000) && (s2 == 64'hFFFF_FFFF_FFFF_FFFF);
    if (w) begin
      case (op)
        OP_DIV:  if (wub == 0) r32 = 32'hFFFF_FFFF; else if (ovf32) r32 = s1[31:0]; else r32 = wa / wb;
        OP_DIVU: if (wub == 0) r32 = 32'hFFFF_FFFF; else r32 = wua / wub;
        OP_REM:  if (wub == 0) r32 = s1[31:0]; else if (ovf32) r32 = 32'd0; else r32 = wa % wb;
        default: if (wub == 0) r32 = s1[31:0]; else r32 = wua % wub;
      endcase
      return sx32(r32);
    end
    case (op)
      OP_DIV:  if (ub == 0) r64 = '1; else if (ovf64) r64 = s1; else r64 = sa / sb;
      OP_DIVU: if (ub == 0) r64 = '1; else r64 = ua / ub;
      OP_REM:  if (ub == 0) r64 = s1; else if (ovf64) r64 = 64'd0; else r64 = sa % sb;
      default: if (ub == 0) r64 = s1; else r64 = ua % ub;
    endcase
    return r64;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input bit w,
                                 input logic [63:0] s1, input logic [63:0] s2);
    bit sgn, zero, ovf;
    sgn  = (op == OP_DIV) || (op == OP_REM);
    zero = w ? (s2[31:0] == 32'd0) : (s2 == 64'd0);
    ovf  = w ? (s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF)
             : (s1 == 64'h8000_0000_0000_0000 && s2 == '1);
    if (!$onehot(op) || zero || (sgn && ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one request, measure edges from accept to res_valid, check the
  // result, optionally apply backpressure for bp cycles, then complete.
  task automatic run_op(input string tag, input logic [3:0] op, input bit w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int elat, input int bp);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_before"}, div_ready, 1);
    div_op = op; inst_32bit = w; div_src1 = a; div_src2 = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    div_op = 4'($urandom); inst_32bit = 1'($urandom);
    div_src1 = {$urandom, $urandom}; div_src2 = {$urandom, $urandom};
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_result"}, div_result, exp);
    chk({tag, "_busy_in_done"}, div_ready, 0);
    for (int i = 0; i < bp; i++) begin
      div_valid = 1'b1; div_op = OP_DIVU; inst_32bit = 1'b0;
      div_src1 = 64'd100; div_src2 = 64'd7;
      @(posedge clk); #1;
      chk({tag, "_bp_result"}, div_result, exp);
      chk({tag, "_bp_valid"}, res_valid, 1);
      chk({tag, "_bp_ready"}, div_ready, 0);
    end
    div_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({tag, "_ready_after"}, div_ready, 1);
    chk({tag, "_valid_after"}, res_valid, 0);
    if (bp > 0) begin
      @(posedge clk); #1;
      chk({tag, "_no_stray_accept"}, div_ready, 1);
    end
  endtask

  task automatic run_rand(input string tag, input logic [3:0] op, input bit w,
                          input logic [63:0] a, input logic [63:0] b);
    run_op(tag, op, w, a, b, ref_div(op, w, a, b), ref_lat(op, w, a, b), 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    bit          w, seen;
    int          r;

    #2 rst = 1'b1;
    #1;
    chk("reset_ready", div_ready, 1);
    chk("reset_valid", res_valid, 0);
    chk("reset_result", div_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_op("div_neg7_2", OP_DIV, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem_neg7_2", OP_REM, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divu_by0", OP_DIVU, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu_by0", OP_REMU, 0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("div_ovf", OP_DIV, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    run_op("divw_ovf", OP_DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("divuw", OP_DIVU, 1, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    run_op("remw", OP_REM, 1, -64'sd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
    run_op("bad_op", 4'b0011, 0, 64'd9, 64'd3, 64'd0, 1, 0);
    run_op("backpressure", OP_DIVU, 0, 64'd1000, 64'd7, 64'd142, 65, 5);

    // flush at cycle 10 of CALC
    @(negedge clk);
    div_op = OP_DIV; inst_32bit = 1'b0; div_src1 = 64'd12345; div_src2 = 64'd7; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", div_ready, 1);
    chk("flush_valid", res_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      seen |= res_valid;
    end
    chk("flush_no_result", seen, 0);

    // flush together with a request in IDLE blocks the accept
    @(negedge clk);
    div_op = OP_DIVU; div_src1 = 64'd50; div_src2 = 64'd5; div_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", div_ready, 1);
    run_op("after_flush", OP_DIVU, 0, 64'd50, 64'd5, 64'd10, 65, 0);

    // async reset in the middle of CALC
    @(negedge clk);
    div_op = OP_REMU; inst_32bit = 1'b0; div_src1 = 64'd77; div_src2 = 64'd10; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("midrst_ready", div_ready, 1);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_result", div_result, 0);
    @(negedge clk) rst = 1'b0;
    run_op("after_rst", OP_REMU, 0, 64'd77, 64'd10, 64'd7, 65, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      op = (r < 8) ? 4'(4'b0001 << (r % 4)) : 4'($urandom);
      w  = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = w ? {32'($urandom), 32'h8000_0000} : 64'h8000_0000_0000_0000;
        1:       a = 64'($urandom_range(0, 1000));
        2:       a = -64'($urandom_range(0, 1000));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       b = w ? {32'($urandom), 32'd0} : 64'd0;
        1:       b = '1;
        2:       b = 64'($urandom_range(1, 50));
        3:       b = -64'($urandom_range(1, 50));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
      endcase
      run_rand($sformatf("rand%0d", k), op, w, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
